// File: rtl/mdu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: opcode values,
// FSM states and small opcode classification helpers.
`timescale 1ns/1ps
package mdu_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

    function automatic logic is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: full-width products and truncating division,
// including the divide-by-zero and signed-overflow results.
`timescale 1ns/1ps
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic signed [2*WIDTH-1:0] a_sx;
    logic signed [2*WIDTH-1:0] b_sx;
    logic [2*WIDTH-1:0]        prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic                      b_zero;
    logic                      s_ovf;
    logic [WIDTH-1:0]          div_bu;
    logic [WIDTH-1:0]          div_bs;
    logic [WIDTH-1:0]          quo_u;
    logic [WIDTH-1:0]          rem_u;
    logic [WIDTH-1:0]          quo_s;
    logic [WIDTH-1:0]          rem_s;

    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign b_zero = (b == '0);
    assign s_ovf  = (a == MOST_NEG) && (b == '1);

    // Corner cases are muxed in below; the dividers only ever see a safe divisor.
    assign div_bu = b_zero ? ONE : b;
    assign div_bs = (b_zero || s_ovf) ? ONE : b;

    assign quo_u = a / div_bu;
    assign rem_u = a % div_bu;
    assign quo_s = $signed(a) / $signed(div_bs);
    assign rem_s = $signed(a) % $signed(div_bs);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (b_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else if (s_ovf) begin
                    res_hi = '0;
                    res_lo = MOST_NEG;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            MD_DIVU: begin
                if (b_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_multicycle.sv
// Execute-stage multiply/divide unit: computes at issue, holds the result for a
// fixed latency, then commits to HI/LO with a done pulse unless flushed.
`timescale 1ns/1ps
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    if (is_muldiv(op)) begin
                        p_hi_d  = res_hi;
                        p_lo_d  = res_lo;
                        cnt_d   = is_mult(op) ? MULT_CNT : DIV_CNT;
                        state_d = ST_BUSY;
                    end else if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_BUSY: begin
                // Flush wins over completion: a flushed result never reaches HI/LO.
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign stall_req = busy || (op_valid && is_muldiv(op));
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Bench for mdu_multicycle: edge-indexed behavioural model with long-integer
// arithmetic, directed corner cases with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_mdu_multicycle;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: committed HI/LO plus at most one in-flight result with the
    // edge number on which it is due to land.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_inflight, m_done;
    int          m_commit_edge;
    int          edge_no = 0;

    mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] rh, output logic [31:0] rl);
        longint          sx, sy, p, q, r;
        longint unsigned pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = '0;
        rl = '0;
        case (o)
            3'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin pu = {32'd0, x} * {32'd0, y}; rh = pu[63:32]; rl = pu[31:0]; end
            3'd2: begin
                if (y == 32'd0) begin rh = x; rl = 32'hFFFF_FFFF; end
                else begin q = sx / sy; r = sx % sy; rh = r[31:0]; rl = q[31:0]; end
            end
            3'd3: begin
                if (y == 32'd0) begin rh = x; rl = 32'hFFFF_FFFF; end
                else begin rh = x % y; rl = x / y; end
            end
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
        m_inflight = 1'b0; m_done = 1'b0; m_commit_edge = 0;
    endfunction

    // One clock cycle: drive inputs mid-cycle, check stall_req, advance the
    // model across the coming edge, then check the registered outputs.
    task automatic step(input logic ov, input logic [2:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic fl);
        op_valid = ov; op = o; a = aa; b = bb; flush = fl;
        #1;
        check("stall_req", {31'd0, stall_req}, {31'd0, m_inflight || (ov && o <= 3'd3)});
        m_done = 1'b0;
        if (m_inflight) begin
            if (fl) m_inflight = 1'b0;
            else if (edge_no + 1 == m_commit_edge) begin
                m_hi = m_phi; m_lo = m_plo; m_done = 1'b1; m_inflight = 1'b0;
            end
        end else if (ov && !fl) begin
            if (o <= 3'd3) begin
                ref_op(o, aa, bb, m_phi, m_plo);
                m_inflight    = 1'b1;
                m_commit_edge = edge_no + 1 + ((o <= 3'd1) ? MULT_LAT : DIV_LAT);
            end else if (o == 3'd4) m_hi = aa;
            else if (o == 3'd5) m_lo = aa;
        end
        edge_no++;
        @(posedge clk);
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_inflight});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   busy_n;
        logic seen;
        step(1'b1, o, aa, bb, 1'b0);
        busy_n = busy ? 1 : 0;
        seen   = 1'b0;
        for (int k = 0; k < lat + 4 && !seen; k++) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_busy_cycles"}, busy_n, lat);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] rh, rl;
        int          held;

        // Pin the reference model itself with hand-computed results.
        ref_op(3'd0, 32'hFFFF_FFFE, 32'd3, rh, rl);
        check("model_mult_hi", rh, 32'hFFFF_FFFF);
        check("model_mult_lo", rl, 32'hFFFF_FFFA);
        ref_op(3'd2, -32'd17, 32'd5, rh, rl);
        check("model_div_neg", {rh[15:0], rl[15:0]}, 32'hFFFE_FFFD);
        ref_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl);
        check("model_div_ovf_lo", rl, 32'h8000_0000);
        check("model_div_ovf_hi", rh, 32'd0);

        model_reset();
        reset = 1'b0; op_valid = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", {31'd0, stall_req}, 32'd0);
        #2 reset = 1'b1;

        run_op("mult",     3'd0, 32'hFFFF_FFFE, 32'd3, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("divu",     3'd3, 32'd17, 32'd5, DIV_LAT, 32'd2, 32'd3);
        run_op("div_neg",  3'd2, -32'd17, 32'd5, DIV_LAT, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("div_zero", 3'd2, 32'h1234, 32'd0, DIV_LAT, 32'h1234, 32'hFFFF_FFFF);
        run_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000);

        // Flush on the final busy cycle discards the product.
        step(1'b1, 3'd4, 32'hA, 32'd0, 1'b0);
        step(1'b1, 3'd5, 32'hB, 32'd0, 1'b0);
        step(1'b1, 3'd1, 32'd7, 32'd6, 1'b0);
        repeat (MULT_LAT - 1) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, 32'hA);
        check("flush_lo", lo, 32'hB);

        // Asynchronous reset in the middle of a multiply.
        step(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #3 reset = 1'b0;
        #0.5;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_hi", hi, 32'd0);
        check("areset_lo", lo, 32'd0);
        model_reset();
        #0.5 reset = 1'b1;
        step(1'b1, 3'd5, 32'h55, 32'd0, 1'b0);
        check("mtlo_after_reset", lo, 32'h55);

        // A MULT held in E by the stall while a DIVU is in flight is ignored.
        step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        held = 0;
        while (m_inflight && held < DIV_LAT + 4) begin
            step(1'b1, 3'd0, $urandom, $urandom, 1'b0);
            held++;
        end
        check("held_cycles", held, DIV_LAT);
        check("held_done", {31'd0, done}, 32'd1);
        check("held_hi", hi, 32'd2);
        check("held_lo", lo, 32'd14);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        while (m_inflight && held < 40) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
            held++;
        end

        // Random traffic: bubbles, all opcodes, flushes and stalled ops.
        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (m_inflight)
                step(r < 60, 3'($urandom_range(0, 7)), pick(), pick(), r >= 94);
            else
                step(r < 75, 3'($urandom_range(0, 7)), pick(), pick(), r >= 95);
        end
        for (int i = 0; i < DIV_LAT + 2; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
